// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_arbiter
// Purpose  : Two-port round-robin arbiter/sequencer for the shared register bus.
// Revision : 1.0  initial release
// ============================================================================
module reg_bus_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_m0_req,
   input  logic              i_m0_we,
   input  logic [ADDR_W-1:0] i_m0_addr,
   input  logic [DATA_W-1:0] i_m0_wdata,
   output logic              o_m0_ack,
   output logic [DATA_W-1:0] o_m0_rdata,
   input  logic              i_m1_req,
   input  logic              i_m1_we,
   input  logic [ADDR_W-1:0] i_m1_addr,
   input  logic [DATA_W-1:0] i_m1_wdata,
   output logic              o_m1_ack,
   output logic [DATA_W-1:0] o_m1_rdata,
   output logic              o_bus_wr,
   output logic              o_bus_rd,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic [DATA_W-1:0] o_bus_wdata,
   input  logic [DATA_W-1:0] i_bus_rdata,
   output logic              o_busy,
   output logic              o_grant
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Counter value on the last WAIT cycle; unused when the read is captured in ISSUE.
   localparam logic [1:0] c_LAST_WAIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
   localparam bit         c_NO_WAIT   = (RD_LAT == 0);

   state_t              state_q, state_d;
   logic                grant_q, grant_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                wr_q, wr_d;
   logic                rd_q, rd_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d;
   logic [DATA_W-1:0]   rdata1_q, rdata1_d;
   logic                busy_q, busy_d;
   logic [1:0]          cnt_q, cnt_d;

   logic                w_any_req;
   logic                w_winner;
   logic                w_win_we;
   logic [ADDR_W-1:0]   w_win_addr;
   logic [DATA_W-1:0]   w_win_wdata;
   logic                w_capture;

   // On contention the port that did not own the last transaction wins.
   assign w_any_req   = i_m0_req | i_m1_req;
   assign w_winner    = (i_m0_req & i_m1_req) ? ~grant_q : i_m1_req;
   assign w_win_we    = w_winner ? i_m1_we    : i_m0_we;
   assign w_win_addr  = w_winner ? i_m1_addr  : i_m0_addr;
   assign w_win_wdata = w_winner ? i_m1_wdata : i_m0_wdata;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      wr_d      = 1'b0;
      rd_d      = 1'b0;
      w_capture = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_any_req) begin
               grant_d = w_winner;
               we_d    = w_win_we;
               addr_d  = w_win_addr;
               wdata_d = w_win_wdata;
               wr_d    = w_win_we;
               rd_d    = ~w_win_we;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d = 2'd0;
            if (we_q) begin
               state_d = S_DONE;
            end else if (c_NO_WAIT) begin
               w_capture = 1'b1;
               state_d   = S_DONE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == c_LAST_WAIT) begin
               w_capture = 1'b1;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (w_capture) begin
         if (grant_q) begin
            rdata1_d = i_bus_rdata;
         end else begin
            rdata0_d = i_bus_rdata;
         end
      end

      // Outputs are registered, so they are derived from the upcoming state.
      ack0_d = (state_d == S_DONE) && !grant_d;
      ack1_d = (state_d == S_DONE) &&  grant_d;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         grant_q  <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         busy_q   <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end

   assign o_m0_ack    = ack0_q;
   assign o_m1_ack    = ack1_q;
   assign o_m0_rdata  = rdata0_q;
   assign o_m1_rdata  = rdata1_q;
   assign o_bus_wr    = wr_q;
   assign o_bus_rd    = rd_q;
   assign o_bus_addr  = addr_q;
   assign o_bus_wdata = wdata_q;
   assign o_busy      = busy_q;
   assign o_grant     = grant_q;

endmodule
`default_nettype wire
